// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ requesters,
// launching each frame with a tx_intr pulse and acknowledging its completion.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int IDX_W         = 2,
    parameter int INTR_LEN      = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant_ack,
    output logic                 tx_intr,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDX_W-1:0]     owner,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int CNT_MAX = (INTR_LEN > START_TIMEOUT) ? INTR_LEN : START_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INTR_LAST  = CNT_W'(INTR_LEN);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [IDX_W:0]   N_REQ_EXT  = (IDX_W+1)'(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_START,
        WAIT_END,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W:0]   cand;
    logic [7:0]       win_byte;

    // Scan rr_ptr+1, rr_ptr+2, ... wrapping at N_REQ; the extra bit keeps the sum from wrapping early.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= N_REQ_EXT) begin
                cand = cand - N_REQ_EXT;
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= IDX_W'(N_REQ - 1);
            cnt         <= '0;
            tx_intr     <= 1'b0;
            tx_data     <= '0;
            grant_ack   <= '0;
            owner       <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            grant_ack   <= '0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    // A stale frame still on the line blocks the launch.
                    if (win_found && !tx_busy) begin
                        owner   <= win_idx;
                        tx_data <= win_byte;
                        tx_intr <= 1'b1;
                        cnt     <= CNT_W'(1);
                        busy    <= 1'b1;
                        state   <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt == INTR_LAST) begin
                        tx_intr <= 1'b0;
                        cnt     <= '0;
                        state   <= WAIT_START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_END;
                    end else if (cnt == START_LAST) begin
                        // Request stays pending; rr_ptr=owner makes it retry after the others.
                        err_timeout <= 1'b1;
                        rr_ptr      <= owner;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_END: begin
                    if (!tx_busy) begin
                        grant_ack[owner] <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= owner;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    tx_intr <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
